// File: rtl/prio_arbiter.sv
// prio_arbiter: registered N-way arbiter with grant hold-until-release.
//
// A client raises req[i] and keeps it high while it needs the shared resource.
// The arbiter picks one owner per arbitration, drives a registered one-hot gnt
// plus its binary index, and keeps that owner until it drops its request. When
// the owner releases, the same edge re-arbitrates over the remaining requests,
// so ownership can move without an idle cycle.
//
// Selection modes (run-time, via mode):
//   0 - fixed priority, highest set index wins
//   1 - round-robin, scan upward from ptr with wrap; ptr = winner + 1 on grant
//
// Optional build macro ARB_MAX_HOLD_EN:
//   When defined, an owner that has held for MAX_HOLD cycles is forced off the
//   grant if any other client is waiting. When undefined, hold time is
//   unlimited and MAX_HOLD is unused apart from its range check.
//
// Parameters:
//   N        number of requesters (2..32)
//   IDXW     width of grant_idx, derived from N; do not override
//   MAX_HOLD maximum consecutive ownership cycles (>= 1), ARB_MAX_HOLD_EN only
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   mode       0 = fixed priority, 1 = round-robin
//   req        request vector, one bit per client
//   gnt        registered one-hot grant, zero when idle
//   grant_idx  registered index of the owner, holds last value while idle
//   idle       registered, high exactly when gnt is zero
module prio_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned IDXW     = $clog2(N),
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] grant_idx,
  output logic            idle
);

  if ((N < 2) || (N > 32)) begin : g_bad_n
    $error("prio_arbiter: N must be in 2..32");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("prio_arbiter: MAX_HOLD must be >= 1");
  end

  localparam logic [IDXW:0] NumReq = (IDXW + 1)'(N);

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  state_e          state_q;
  logic [N-1:0]    gnt_q;
  logic [IDXW-1:0] grant_idx_q;
  logic            idle_q;
  logic [IDXW-1:0] ptr_q;

  logic            owner_req;
  logic [N-1:0]    owner_mask;
  logic            force_rearb;
  logic [N-1:0]    cand;
  logic            any_cand;
  logic            arb_en;
  logic [IDXW-1:0] fix_idx;
  logic [IDXW-1:0] rr_idx;
  logic [IDXW:0]   rr_pos;
  logic [IDXW-1:0] win_idx;
  logic [N-1:0]    win_onehot;
  logic [IDXW-1:0] ptr_nxt;

  assign owner_req  = req[grant_idx_q];
  assign owner_mask = {{(N-1){1'b0}}, 1'b1} << grant_idx_q;

  // A forced hand-over excludes the current owner from the candidate set.
  assign cand     = force_rearb ? (req & ~owner_mask) : req;
  assign any_cand = |cand;

  // Arbitrate when idle, when the owner lets go, or when its hold time is up.
  assign arb_en = (state_q == StIdle) || !owner_req || force_rearb;

`ifdef ARB_MAX_HOLD_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  logic [CntW-1:0] hold_cnt_q;
  logic            hold_max;

  assign hold_max    = (hold_cnt_q == CntW'(MAX_HOLD));
  assign force_rearb = (state_q == StGrant) && owner_req && hold_max &&
                       (|(req & ~owner_mask));

  // Counts cycles of the current ownership, 1 on the granting edge, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
    end else if (arb_en) begin
      hold_cnt_q <= any_cand ? CntW'(1) : '0;
    end else if (!hold_max) begin
      hold_cnt_q <= hold_cnt_q + CntW'(1);
    end
  end
`else
  assign force_rearb = 1'b0;
`endif

  // Fixed priority: last set bit found scanning upward is the highest index.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) fix_idx = IDXW'(i);
    end
  end

  // Round-robin: walk offsets from N-1 down to 0 so the smallest offset from
  // ptr that hits a set bit is the one left in rr_idx.
  always_comb begin
    rr_idx = '0;
    rr_pos = '0;
    for (int i = N - 1; i >= 0; i--) begin
      rr_pos = {1'b0, ptr_q} + (IDXW + 1)'(i);
      if (rr_pos >= NumReq) rr_pos = rr_pos - NumReq;
      if (cand[rr_pos[IDXW-1:0]]) rr_idx = rr_pos[IDXW-1:0];
    end
  end

  assign win_idx    = mode ? rr_idx : fix_idx;
  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  assign ptr_nxt    = (win_idx == IDXW'(N - 1)) ? '0 : win_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      grant_idx_q <= '0;
      idle_q      <= 1'b1;
      ptr_q       <= '0;
    end else if (arb_en) begin
      if (any_cand) begin
        state_q     <= StGrant;
        gnt_q       <= win_onehot;
        grant_idx_q <= win_idx;
        idle_q      <= 1'b0;
        ptr_q       <= ptr_nxt;
      end else begin
        // grant_idx and ptr keep their values across an idle period.
        state_q <= StIdle;
        gnt_q   <= '0;
        idle_q  <= 1'b1;
      end
    end
  end

  assign gnt       = gnt_q;
  assign grant_idx = grant_idx_q;
  assign idle      = idle_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Directed bench for prio_arbiter with N = 8 and MAX_HOLD = 4. Expected values
// are hand-computed; the hold-limit section picks its expectation according to
// whether ARB_MAX_HOLD_EN is defined for the build.
module tb_prio_arbiter;

  localparam int unsigned N    = 8;
  localparam int unsigned IdxW = 3;

`ifdef ARB_MAX_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic            clk;
  logic            rst_n;
  logic            mode;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [IdxW-1:0] grant_idx;
  logic            idle;

  int checks   = 0;
  int failures = 0;

  prio_arbiter #(
    .N        (N),
    .MAX_HOLD (4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .req       (req),
    .gnt       (gnt),
    .grant_idx (grant_idx),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; outputs are sampled and inputs changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] exp_gnt;

    // Reset with every request asserted.
    rst_n = 1'b0;
    mode  = 1'b0;
    req   = 8'hFF;
    repeat (3) tick();
    check("rst_gnt", gnt, 8'h00);
    check("rst_idx", grant_idx, 0);
    check("rst_idle", idle, 1);
    rst_n = 1'b1;
    tick();
    check("first_gnt", gnt, 8'h80);
    check("first_idx", grant_idx, 7);
    check("first_idle", idle, 0);

    // Fixed priority, hold, direct hand-over.
    req = 8'h26;
    tick();
    check("fix_gnt", gnt, 8'h20);
    check("fix_idx", grant_idx, 5);
    req = 8'hA6;
    tick();
    check("hold_gnt_a", gnt, 8'h20);
    tick();
    check("hold_gnt_b", gnt, 8'h20);
    req = 8'h84;
    tick();
    check("handover_gnt", gnt, 8'h80);
    check("handover_idx", grant_idx, 7);
    check("handover_idle", idle, 0);
    req = 8'h00;
    tick();
    check("release_gnt", gnt, 8'h00);
    check("release_idle", idle, 1);
    check("release_idx", grant_idx, 7);

    // A pulse between edges is never sampled.
    #2 req = 8'h01;
    #2 req = 8'h00;
    tick();
    check("glitch_gnt", gnt, 8'h00);
    check("glitch_idle", idle, 1);

    // Round-robin alternation between clients 0 and 7.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'h81;
    tick();
    check("rr_first", gnt, 8'h01);
    for (int r = 0; r < 2; r++) begin
      req = 8'h80;
      tick();
      check("rr_to7", gnt, 8'h80);
      req = 8'h81;
      tick();
      check("rr_hold7", gnt, 8'h80);
      req = 8'h01;
      tick();
      check("rr_to0", gnt, 8'h01);
      req = 8'h81;
      tick();
      check("rr_hold0", gnt, 8'h01);
    end

    // Pointer wrap: grant 6, idle, then 7, then 0 rather than 6.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'h40;
    tick();
    check("wrap_g6", gnt, 8'h40);
    req = 8'h00;
    tick();
    check("wrap_idle", idle, 1);
    req = 8'hC1;
    tick();
    check("wrap_g7", gnt, 8'h80);
    check("wrap_idx7", grant_idx, 7);
    req = 8'h41;
    tick();
    check("wrap_g0", gnt, 8'h01);
    check("wrap_idx0", grant_idx, 0);
    req = 8'hC0;
    tick();
    check("rr_from1", gnt, 8'h40);

    // Mode change does not disturb the owner; it applies at the next arbitration.
    mode = 1'b0;
    tick();
    check("mode_hold", gnt, 8'h40);
    req = 8'h03;
    tick();
    check("mode_fixed", gnt, 8'h02);

    // Reset in the middle of a grant clears ptr too.
    req = 8'h08;
    tick();
    check("mid_owner3", gnt, 8'h08);
    rst_n = 1'b0;
    tick();
    check("mid_rst_gnt", gnt, 8'h00);
    check("mid_rst_idle", idle, 1);
    check("mid_rst_idx", grant_idx, 0);
    rst_n = 1'b1;
    mode  = 1'b1;
    req   = 8'h21;
    tick();
    check("mid_ptr0", gnt, 8'h01);

    // Hold limit: owner 3 loses the grant after 4 cycles only with the feature.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mode  = 1'b0;
    req   = 8'h08;
    tick();
    check("mh_owner3", gnt, 8'h08);
    req = 8'h0A;
    for (int t = 1; t <= 5; t++) begin
      tick();
      exp_gnt = (HoldEn && (t >= 4)) ? 8'h02 : 8'h08;
      check("mh_cycle", gnt, exp_gnt);
    end
    req = 8'h08;
    tick();
    check("mh_return", gnt, 8'h08);
    for (int t = 0; t < 6; t++) begin
      tick();
      check("mh_alone", gnt, 8'h08);
    end
    req = 8'h0A;
    tick();
    exp_gnt = HoldEn ? 8'h02 : 8'h08;
    check("mh_saturated", gnt, exp_gnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
